// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse access arbiter.
// Holds the FSM state enum, controller mode codes and grant encodings.
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_e;

    localparam logic [1:0] MODE_PROG = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_AUTO = 2'b01;
    localparam logic [1:0] GNT_SC   = 2'b10;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == MODE_PROG) || (m == MODE_READ);
    endfunction

endpackage

// File: rtl/efuse_wdog.sv
// Watchdog counting enabled cycles; expire is high on the TIMEOUT-th one.
// Ports: clk, rst (sync, active-high), en, clr, expire (combinational).
module efuse_wdog
    import efuse_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/efuse_access_arbiter.sv
// Arbitrates autoload and slow-control access to one eFuse controller.
// Ports: clk, rst (sync, active-high); auto_req/auto_ack and sc_req/sc_ack
// handshakes with sc_mode/sc_prog/sc_tckhp; efuse_busy in; efuse_start,
// efuse_mode, efuse_prog, efuse_tckhp to the controller; grant (one-hot
// owner) and err (valid with an ack). Define EFUSE_TIMEOUT_EN to enable
// the busy watchdog (efuse_wdog, limit TIMEOUT cycles).
module efuse_access_arbiter #(
    parameter int unsigned START_LEN  = 8,
    parameter int unsigned AUTO_TCKHP = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_req,
    input  logic        sc_req,
    input  logic [1:0]  sc_mode,
    input  logic [31:0] sc_prog,
    input  logic [3:0]  sc_tckhp,
    input  logic        efuse_busy,
    output logic        efuse_start,
    output logic [1:0]  efuse_mode,
    output logic [31:0] efuse_prog,
    output logic [3:0]  efuse_tckhp,
    output logic [1:0]  grant,
    output logic        auto_ack,
    output logic        sc_ack,
    output logic        err
);

    import efuse_pkg::*;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_auto_q, last_auto_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] prog_q, prog_d;
    logic [3:0]  tckhp_q, tckhp_d;
    logic        auto_ack_q, auto_ack_d;
    logic        sc_ack_q, sc_ack_d;
    logic        err_q, err_d;
    logic        pick_sc;
    logic        wd_expire;

`ifdef EFUSE_TIMEOUT_EN
    logic wd_en;

    assign wd_en = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    efuse_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (!wd_en),
        .expire (wd_expire)
    );
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT;
    assign wd_expire  = 1'b0;
`endif

    // sc wins a contention only when auto had the previous grant.
    assign pick_sc = sc_req && (!auto_req || last_auto_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_auto_d = last_auto_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        mode_d      = mode_q;
        prog_d      = prog_q;
        tckhp_d     = tckhp_q;
        auto_ack_d  = 1'b0;
        sc_ack_d    = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!efuse_busy && (auto_req || sc_req)) begin
                    cnt_d = '0;
                    if (pick_sc) begin
                        grant_d     = GNT_SC;
                        last_auto_d = 1'b0;
                        mode_d      = sc_mode;
                        prog_d      = sc_prog;
                        tckhp_d     = sc_tckhp;
                        if (mode_legal(sc_mode)) begin
                            state_d = START;
                        end else begin
                            state_d  = ACK;
                            sc_ack_d = 1'b1;
                            err_d    = 1'b1;
                        end
                    end else begin
                        grant_d     = GNT_AUTO;
                        last_auto_d = 1'b1;
                        mode_d      = MODE_READ;
                        prog_d      = '0;
                        tckhp_d     = 4'(AUTO_TCKHP);
                        state_d     = START;
                    end
                end
            end
            START: begin
                // start is registered, so it trails the state by one cycle.
                start_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'(START_LEN)) begin
                    start_d = 1'b0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (wd_expire) begin
                    state_d    = ACK;
                    auto_ack_d = (grant_q == GNT_AUTO);
                    sc_ack_d   = (grant_q == GNT_SC);
                    err_d      = 1'b1;
                end else if (efuse_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wd_expire || !efuse_busy) begin
                    state_d    = ACK;
                    auto_ack_d = (grant_q == GNT_AUTO);
                    sc_ack_d   = (grant_q == GNT_SC);
                    err_d      = wd_expire;
                end
            end
            ACK: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
                mode_d  = '0;
                prog_d  = '0;
                tckhp_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            last_auto_q <= 1'b0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            mode_q      <= '0;
            prog_q      <= '0;
            tckhp_q     <= '0;
            auto_ack_q  <= 1'b0;
            sc_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_auto_q <= last_auto_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            mode_q      <= mode_d;
            prog_q      <= prog_d;
            tckhp_q     <= tckhp_d;
            auto_ack_q  <= auto_ack_d;
            sc_ack_q    <= sc_ack_d;
            err_q       <= err_d;
        end
    end

    assign efuse_start = start_q;
    assign efuse_mode  = mode_q;
    assign efuse_prog  = prog_q;
    assign efuse_tckhp = tckhp_q;
    assign grant       = grant_q;
    assign auto_ack    = auto_ack_q;
    assign sc_ack      = sc_ack_q;
    assign err         = err_q;

endmodule
